// File: rtl/sw_pe_array_64.sv
// Linear systolic Smith-Waterman array: 64 PEs score one B stripe against streamed A and
// report the stripe maximum, its earliest column and the bottom-row maximum column.

module sw_pe #(
    parameter int BASE_W  = 2,
    parameter int SCORE_W = 14
) (
    input  logic               gclk,
    input  logic               grst_n,
    input  logic               clr,
    input  logic [BASE_W-1:0]  b,
    input  logic               v_in,
    input  logic [BASE_W-1:0]  a_in,
    input  logic [SCORE_W-1:0] up_h,
    input  logic [SCORE_W-1:0] up_cm,
    output logic [SCORE_W-1:0] h,
    output logic [SCORE_W-1:0] cm
);
    localparam logic [SCORE_W-1:0] SAT = '1;
    localparam logic [SCORE_W-1:0] ONE = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] TWO = SCORE_W'(2);

    logic [SCORE_W-1:0] diag_q;
    logic [SCORE_W-1:0] diag_sc, up_sc, left_sc, h_nxt, cm_nxt;

    // Gap and mismatch terms floor at 0, which folds the max(0, ...) clause in.
    always_comb begin
        if (a_in == b)
            diag_sc = (diag_q > SAT - TWO) ? SAT : diag_q + TWO;
        else
            diag_sc = (diag_q != '0) ? diag_q - ONE : '0;
        up_sc   = (up_h != '0) ? up_h - ONE : '0;
        left_sc = (h != '0) ? h - ONE : '0;
        h_nxt   = diag_sc;
        if (up_sc > h_nxt)
            h_nxt = up_sc;
        if (left_sc > h_nxt)
            h_nxt = left_sc;
        cm_nxt  = (h_nxt > up_cm) ? h_nxt : up_cm;
    end

    // cm carries the running max of this column down the rows alongside h.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            h      <= '0;
            diag_q <= '0;
            cm     <= '0;
        end else if (clr) begin
            h      <= '0;
            diag_q <= '0;
            cm     <= '0;
        end else if (v_in) begin
            h      <= h_nxt;
            diag_q <= up_h;
            cm     <= cm_nxt;
        end
    end
endmodule

module sw_pe_array_64 (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_B,
    input  logic [1:0]   i_A,
    output logic         o_stripe_end,
    output logic [9:0]   o_start_position,
    output logic [9:0]   o_end_position,
    output logic [13:0]  o_max_score_stripe
);
    localparam int NUM_PE  = 64;
    localparam int BASE_W  = 2;
    localparam int SCORE_W = 14;
    localparam int POS_W   = 10;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nxt;
    logic   capture, inject, finish;
    logic [5:0] drain_cnt;

    logic [NUM_PE-1:0][BASE_W-1:0]  b_q;
    logic [NUM_PE-1:0][BASE_W-1:0]  a_pipe;
    logic [NUM_PE:0]                vld_pipe;
    logic [NUM_PE:0][SCORE_W-1:0]   h_pipe;
    logic [NUM_PE:0][SCORE_W-1:0]   cm_pipe;

    logic [SCORE_W-1:0] g_max, g_max_nxt, b_max, b_max_nxt;
    logic [POS_W-1:0]   g_col, g_col_nxt, b_col, b_col_nxt, col_q;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        inject    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    capture   = 1'b1;
                    inject    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (i_start)
                    inject = 1'b1;
                else
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == 6'd63) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            drain_cnt <= '0;
        else if (state != DRAIN)
            drain_cnt <= '0;
        else
            drain_cnt <= drain_cnt + 6'd1;
    end

    // A bases and their valid bits advance one PE per edge; PE p sees column c at edge c+p+1.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            b_q      <= '0;
            a_pipe   <= '0;
            vld_pipe <= '0;
        end else begin
            if (capture)
                b_q <= i_B;
            a_pipe   <= {a_pipe[NUM_PE-2:0], i_A};
            vld_pipe <= {vld_pipe[NUM_PE-1:0], inject};
        end
    end

    assign h_pipe[0]  = '0;
    assign cm_pipe[0] = '0;

    for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
        sw_pe #(
            .BASE_W (BASE_W),
            .SCORE_W(SCORE_W)
        ) u_pe (
            .gclk  (i_clk),
            .grst_n(i_rst),
            .clr   (capture),
            .b     (b_q[p]),
            .v_in  (vld_pipe[p]),
            .a_in  (a_pipe[p]),
            .up_h  (h_pipe[p]),
            .up_cm (cm_pipe[p]),
            .h     (h_pipe[p+1]),
            .cm    (cm_pipe[p+1])
        );
    end

    // Columns leave PE63 in order, so strict-greater keeps the earliest column on ties.
    always_comb begin
        g_max_nxt = g_max;
        g_col_nxt = g_col;
        b_max_nxt = b_max;
        b_col_nxt = b_col;
        if (vld_pipe[NUM_PE]) begin
            if (cm_pipe[NUM_PE] > g_max) begin
                g_max_nxt = cm_pipe[NUM_PE];
                g_col_nxt = col_q;
            end
            if (h_pipe[NUM_PE] > b_max) begin
                b_max_nxt = h_pipe[NUM_PE];
                b_col_nxt = col_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            g_max <= '0;
            g_col <= '0;
            b_max <= '0;
            b_col <= '0;
            col_q <= '0;
        end else if (capture) begin
            g_max <= '0;
            g_col <= '0;
            b_max <= '0;
            b_col <= '0;
            col_q <= '0;
        end else begin
            g_max <= g_max_nxt;
            g_col <= g_col_nxt;
            b_max <= b_max_nxt;
            b_col <= b_col_nxt;
            if (vld_pipe[NUM_PE])
                col_q <= col_q + POS_W'(1);
        end
    end

    // The last column reaches the trackers on the finishing edge, so load from the next-state terms.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_stripe_end       <= 1'b0;
            o_start_position   <= '0;
            o_end_position     <= '0;
            o_max_score_stripe <= '0;
        end else begin
            o_stripe_end <= finish;
            if (finish) begin
                o_start_position   <= b_col_nxt;
                o_end_position     <= g_col_nxt;
                o_max_score_stripe <= g_max_nxt;
            end
        end
    end
endmodule

// File: tb/tb_sw_pe_array_64.sv
// Randomized and directed stripes for sw_pe_array_64, scored against a full-matrix
// Smith-Waterman reference evaluated row by row.

module tb_sw_pe_array_64;
    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_start = 1'b0;
    logic [127:0] i_B = '0;
    logic [1:0]   i_A = '0;
    logic         o_stripe_end;
    logic [9:0]   o_start_position;
    logic [9:0]   o_end_position;
    logic [13:0]  o_max_score_stripe;

    sw_pe_array_64 dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_start           (i_start),
        .i_B               (i_B),
        .i_A               (i_A),
        .o_stripe_end      (o_stripe_end),
        .o_start_position  (o_start_position),
        .o_end_position    (o_end_position),
        .o_max_score_stripe(o_max_score_stripe)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;
    int hold_max = 0, hold_end = 0, hold_start = 0;
    logic [1:0] a_seq[$];
    int row_prev[1024];
    int row_cur[1024];

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Full DP over rows 0..63 and columns 0..n-1 with zero boundaries.
    task automatic ref_model(input logic [127:0] b, input int n,
                             output int mx, output int ecol, output int scol);
        int bm;
        mx = 0; ecol = 0; scol = 0; bm = 0;
        for (int c = 0; c < n; c++) row_prev[c] = 0;
        for (int p = 0; p < 64; p++) begin
            for (int c = 0; c < n; c++) begin
                int d, u, l, h;
                d = (c == 0) ? 0 : row_prev[c-1];
                u = row_prev[c];
                l = (c == 0) ? 0 : row_cur[c-1];
                h = d + ((b[2*p +: 2] == a_seq[c]) ? 2 : -1);
                if (u - 1 > h) h = u - 1;
                if (l - 1 > h) h = l - 1;
                if (h < 0) h = 0;
                if (h > 16383) h = 16383;
                row_cur[c] = h;
                if (h > mx || (h == mx && c < ecol)) begin
                    mx = h;
                    ecol = c;
                end
                if (p == 63 && h > bm) begin
                    bm = h;
                    scol = c;
                end
            end
            for (int c = 0; c < n; c++) row_prev[c] = row_cur[c];
        end
    endtask

    // Entered just after a negedge; returns at the negedge where o_stripe_end is seen.
    task automatic run_stripe(input logic [127:0] b, input string name);
        int n, mx, ec, sc, lat;
        n = a_seq.size();
        ref_model(b, n, mx, ec, sc);
        i_B = b;
        i_start = 1'b1;
        i_A = a_seq[0];
        for (int k = 1; k < n; k++) begin
            @(negedge i_clk);
            i_A = a_seq[k];
            i_B = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge i_clk);
        i_start = 1'b0;
        i_A = 2'($urandom);
        chk({name, "/hold_max"}, int'(o_max_score_stripe), hold_max);
        chk({name, "/hold_end"}, int'(o_end_position), hold_end);
        chk({name, "/hold_start"}, int'(o_start_position), hold_start);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge i_clk);
            if (o_stripe_end) begin
                lat = k;
                break;
            end
            i_A = 2'($urandom);
            i_start = (k <= 60) ? 1'($urandom) : 1'b0;
        end
        i_start = 1'b0;
        chk({name, "/latency"}, lat, 65);
        chk({name, "/max"}, int'(o_max_score_stripe), mx);
        chk({name, "/end"}, int'(o_end_position), ec);
        chk({name, "/start"}, int'(o_start_position), sc);
        hold_max = mx;
        hold_end = ec;
        hold_start = sc;
    endtask

    task automatic pulse_low(input string name);
        @(negedge i_clk);
        chk({name, "/pulse_width"}, int'(o_stripe_end), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] b;
        int pulses;
        #2 i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst/end", int'(o_stripe_end), 0);
        chk("rst/max", int'(o_max_score_stripe), 0);
        chk("rst/end_pos", int'(o_end_position), 0);
        chk("rst/start_pos", int'(o_start_position), 0);
        i_rst = 1'b1;
        @(negedge i_clk);

        a_seq.delete();
        for (int c = 0; c < 1024; c++) a_seq.push_back(2'd0);
        run_stripe('0, "all_match");
        pulse_low("all_match");

        a_seq.delete();
        for (int c = 0; c < 1024; c++) a_seq.push_back(2'd3);
        run_stripe('0, "no_match");
        pulse_low("no_match");

        a_seq.delete();
        for (int c = 0; c < 40; c++) a_seq.push_back((c == 10) ? 2'd2 : 2'd3);
        b = '0;
        b[1:0] = 2'd2;
        run_stripe(b, "single_hit");
        pulse_low("single_hit");

        a_seq.delete();
        for (int c = 0; c < 5; c++) a_seq.push_back(2'd0);
        run_stripe('0, "short");

        // Back-to-back: second stripe starts in the pulse cycle of the first.
        a_seq.delete();
        for (int c = 0; c < 90; c++) a_seq.push_back(2'($urandom_range(0, 1)));
        run_stripe({$urandom, $urandom, 32'h0, 32'h0}, "b2b_a");
        a_seq.delete();
        for (int c = 0; c < 70; c++) a_seq.push_back(2'($urandom_range(0, 3)));
        run_stripe({4{32'h5555_0000}}, "b2b_b");
        pulse_low("b2b_b");

        // Reset mid-RUN: outputs clear at once and the aborted stripe never reports.
        i_B = {$urandom, $urandom, $urandom, $urandom};
        i_start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            i_A = 2'($urandom);
            @(negedge i_clk);
        end
        i_rst = 1'b0;
        #1;
        chk("mid_rst/max", int'(o_max_score_stripe), 0);
        chk("mid_rst/end_pos", int'(o_end_position), 0);
        chk("mid_rst/start_pos", int'(o_start_position), 0);
        i_start = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge i_clk);
            if (o_stripe_end) pulses++;
        end
        chk("mid_rst/no_pulse", pulses, 0);
        hold_max = 0;
        hold_end = 0;
        hold_start = 0;

        for (int s = 0; s < 12; s++) begin
            int n;
            bit narrow;
            n = $urandom_range(1, 200);
            narrow = 1'($urandom);
            a_seq.delete();
            for (int c = 0; c < n; c++)
                a_seq.push_back(narrow ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3)));
            for (int p = 0; p < 64; p++)
                b[2*p +: 2] = narrow ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
            run_stripe(b, $sformatf("rand%0d", s));
            if ($urandom_range(0, 1) == 1) begin
                pulse_low($sformatf("rand%0d", s));
                repeat ($urandom_range(0, 5)) @(negedge i_clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
